// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings and constants for the instruction fetch sequencer.
// Imported by the top and by the wait-counter sub-module.
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      WAIT   = 2'd1,
      FETCH  = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   localparam int unsigned PC_INC = 32'd4;

   // Redirect targets are word aligned; slice to PC_WIDTH at the point of use.
   localparam logic [63:0] ALIGN_MASK = ~64'h0000_0000_0000_0003;

   localparam int unsigned WAIT_CNT_WIDTH = 32'd4;

endpackage

// File: rtl/fetch_wait_counter.sv
// Loadable down-counter pacing instruction-memory wait states.
// done is high while the count sits at 1, i.e. the last wait cycle.
module fetch_wait_counter
   import fetch_sequencer_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [WAIT_CNT_WIDTH-1:0] load_value,
   input  logic                      dec,
   output logic                      done
);

   logic [WAIT_CNT_WIDTH-1:0] count_r;

   // Load takes priority over decrement; the count never underflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {WAIT_CNT_WIDTH{1'b0}};
      end else if (load) begin
         count_r <= load_value;
      end else if (dec && (count_r != {WAIT_CNT_WIDTH{1'b0}})) begin
         count_r <= count_r - {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r == {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, paces fetches to the instruction-memory
// latency and drives the IF/ID write and flush controls.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                  PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
   parameter int                  IMEM_WAIT = 0,
   parameter int                  CNT_WIDTH = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Stall,
   input  logic                 Redirect,
   input  logic [PC_WIDTH-1:0]  RedirectPC,
   input  logic                 Halt,
   output logic [PC_WIDTH-1:0]  PCResult,
   output logic                 FetchValid,
   output logic                 IFIDWrite,
   output logic                 IFIDFlush,
   output logic                 Halted,
   output logic [CNT_WIDTH-1:0] FetchCount
);

   localparam bit                        USE_WAIT  = (IMEM_WAIT > 0);
   localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_INIT = WAIT_CNT_WIDTH'(IMEM_WAIT);
   localparam fetch_state_e              AFTER_FETCH = USE_WAIT ? WAIT : FETCH;

   fetch_state_e          state_r;
   logic [PC_WIDTH-1:0]   pc_r;
   logic                  fetch_valid_r;
   logic                  halted_r;
   logic [CNT_WIDTH-1:0]  fetch_count_r;

   logic [PC_WIDTH-1:0]   pc_step_s;
   logic [PC_WIDTH-1:0]   redirect_pc_s;
   logic                  wait_load_s;
   logic                  wait_dec_s;
   logic                  wait_done_s;
   logic                  ifid_write_s;

   // Never enters WAIT when IMEM_WAIT is 0, so the counter is then inert.
   fetch_wait_counter u_wait (
      .clk        (Clk),
      .rst_n      (Reset),
      .load       (wait_load_s),
      .load_value (WAIT_INIT),
      .dec        (wait_dec_s),
      .done       (wait_done_s)
   );

   // Next-PC candidates and wait-counter controls.
   always_comb begin
      pc_step_s     = pc_r + PC_WIDTH'(PC_INC);
      redirect_pc_s = RedirectPC & ALIGN_MASK[PC_WIDTH-1:0];
      wait_load_s   = 1'b0;
      wait_dec_s    = 1'b0;
      case (state_r)
         BOOT:  wait_load_s = 1'b1;
         WAIT: begin
            if (Redirect) begin
               wait_load_s = 1'b1;
            end else begin
               wait_dec_s = 1'b1;
            end
         end
         FETCH: begin
            if (Redirect || (!Stall && !Halt)) begin
               wait_load_s = 1'b1;
            end else begin
               wait_load_s = 1'b0;
            end
         end
         default: wait_load_s = 1'b0;
      endcase
   end

   // Sequencer FSM with registered PC, FetchValid and Halted.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r       <= BOOT;
         pc_r          <= RESET_PC;
         fetch_valid_r <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         case (state_r)
            BOOT: begin
               state_r       <= AFTER_FETCH;
               fetch_valid_r <= !USE_WAIT;
            end
            WAIT: begin
               if (Redirect) begin
                  pc_r <= redirect_pc_s;
               end else if (wait_done_s) begin
                  state_r       <= FETCH;
                  fetch_valid_r <= 1'b1;
               end else begin
                  state_r <= WAIT;
               end
            end
            FETCH: begin
               if (Redirect) begin
                  pc_r          <= redirect_pc_s;
                  state_r       <= AFTER_FETCH;
                  fetch_valid_r <= !USE_WAIT;
               end else if (Stall) begin
                  state_r <= FETCH;
               end else if (Halt) begin
                  state_r       <= HALTED;
                  fetch_valid_r <= 1'b0;
                  halted_r      <= 1'b1;
               end else begin
                  pc_r          <= pc_step_s;
                  state_r       <= AFTER_FETCH;
                  fetch_valid_r <= !USE_WAIT;
               end
            end
            HALTED: state_r <= HALTED;
            default: begin
               state_r       <= BOOT;
               fetch_valid_r <= 1'b0;
               halted_r      <= 1'b0;
            end
         endcase
      end
   end

   assign ifid_write_s = fetch_valid_r & ~Stall & ~Redirect;

   // Saturating count of fetches accepted by IF/ID.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fetch_count_r <= {CNT_WIDTH{1'b0}};
      end else if (ifid_write_s && (fetch_count_r != {CNT_WIDTH{1'b1}})) begin
         fetch_count_r <= fetch_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         fetch_count_r <= fetch_count_r;
      end
   end

   assign PCResult   = pc_r;
   assign FetchValid = fetch_valid_r;
   assign IFIDWrite  = ifid_write_s;
   assign IFIDFlush  = Redirect & ((state_r == FETCH) || (state_r == WAIT));
   assign Halted     = halted_r;
   assign FetchCount = fetch_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero-wait, two-wait and a narrow
// fetch-counter instance share clock and control inputs.
module tb_fetch_sequencer;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;

   logic [31:0] pc_a, pc_b, pc_c;
   logic        fv_a, fv_b, fv_c;
   logic        wr_a, wr_b, wr_c;
   logic        fl_a, fl_b, fl_c;
   logic        ht_a, ht_b, ht_c;
   logic [15:0] cnt_a, cnt_b;
   logic [3:0]  cnt_c;

   int checks = 0;
   int errors = 0;

   fetch_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .IMEM_WAIT(0), .CNT_WIDTH(16)) dut_a (
      .Clk(clk), .Reset(reset_n), .Stall(stall), .Redirect(redirect),
      .RedirectPC(redirect_pc), .Halt(halt), .PCResult(pc_a), .FetchValid(fv_a),
      .IFIDWrite(wr_a), .IFIDFlush(fl_a), .Halted(ht_a), .FetchCount(cnt_a));

   fetch_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .IMEM_WAIT(2), .CNT_WIDTH(16)) dut_b (
      .Clk(clk), .Reset(reset_n), .Stall(stall), .Redirect(redirect),
      .RedirectPC(redirect_pc), .Halt(halt), .PCResult(pc_b), .FetchValid(fv_b),
      .IFIDWrite(wr_b), .IFIDFlush(fl_b), .Halted(ht_b), .FetchCount(cnt_b));

   fetch_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .IMEM_WAIT(0), .CNT_WIDTH(4)) dut_c (
      .Clk(clk), .Reset(reset_n), .Stall(stall), .Redirect(redirect),
      .RedirectPC(redirect_pc), .Halt(halt), .PCResult(pc_c), .FetchValid(fv_c),
      .IFIDWrite(wr_c), .IFIDFlush(fl_c), .Halted(ht_c), .FetchCount(cnt_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench just after reset release, with the DUTs in BOOT.
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
      repeat (10) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
      #50;
      checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL reset_pc act=%h exp=%h", pc_a, 32'h0); end
      checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL reset_fv act=%b exp=0", fv_a); end
      checks++; if (ht_a !== 1'b0) begin errors++; $display("FAIL reset_halted act=%b exp=0", ht_a); end
      checks++; if (cnt_a !== 16'h0) begin errors++; $display("FAIL reset_cnt act=%h exp=0", cnt_a); end
      #50;
      reset_n = 1'b1;
      #1;
      checks++; if (fv_a !== 1'b0 || pc_a !== 32'h0) begin errors++; $display("FAIL boot_state act fv=%b pc=%h exp fv=0 pc=0", fv_a, pc_a); end
      step();
      checks++; if (fv_a !== 1'b1) begin errors++; $display("FAIL first_fv act=%b exp=1", fv_a); end
      checks++; if (pc_a !== 32'h0 || wr_a !== 1'b1 || cnt_a !== 16'h0) begin
         errors++; $display("FAIL first_fetch act pc=%h wr=%b cnt=%h exp pc=0 wr=1 cnt=0", pc_a, wr_a, cnt_a); end
      checks++; if (fv_b !== 1'b0) begin errors++; $display("FAIL wait_first_fv act=%b exp=0", fv_b); end
   endtask

   task automatic test_sequence();
      logic [3:0] exp_c;
      do_reset();
      step();
      for (int i = 1; i <= 20; i++) begin
         step();
         exp_c = (i > 15) ? 4'hF : 4'(i);
         checks++; if (pc_a !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] act=%h exp=%h", i, pc_a, 32'(4 * i)); end
         checks++; if (cnt_a !== 16'(i)) begin errors++; $display("FAIL seq_cnt[%0d] act=%h exp=%h", i, cnt_a, 16'(i)); end
         checks++; if (cnt_c !== exp_c) begin errors++; $display("FAIL sat_cnt[%0d] act=%h exp=%h", i, cnt_c, exp_c); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      step();
      repeat (4) step();
      checks++; if (pc_a !== 32'h10) begin errors++; $display("FAIL stall_pre_pc act=%h exp=10", pc_a); end
      stall = 1'b1;
      halt = 1'b1;
      #1;
      checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL stall_wr act=%b exp=0", wr_a); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc_a !== 32'h10 || fv_a !== 1'b1 || cnt_a !== 16'd4 || ht_a !== 1'b0) begin
            errors++; $display("FAIL stall_hold[%0d] act pc=%h fv=%b cnt=%h ht=%b exp pc=10 fv=1 cnt=4 ht=0", i, pc_a, fv_a, cnt_a, ht_a); end
      end
      stall = 1'b0;
      halt = 1'b0;
      #1;
      checks++; if (wr_a !== 1'b1) begin errors++; $display("FAIL stall_release_wr act=%b exp=1", wr_a); end
      step();
      checks++; if (pc_a !== 32'h14 || cnt_a !== 16'd5) begin
         errors++; $display("FAIL stall_resume act pc=%h cnt=%h exp pc=14 cnt=5", pc_a, cnt_a); end
   endtask

   task automatic test_redirect();
      do_reset();
      step();
      repeat (8) step();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
      #1;
      checks++; if (fl_a !== 1'b1 || wr_a !== 1'b0) begin
         errors++; $display("FAIL redir_flush act fl=%b wr=%b exp fl=1 wr=0", fl_a, wr_a); end
      step();
      stall = 1'b0; redirect = 1'b0;
      checks++; if (pc_a !== 32'h100 || fv_a !== 1'b1 || cnt_a !== 16'd8) begin
         errors++; $display("FAIL redir_target act pc=%h fv=%b cnt=%h exp pc=100 fv=1 cnt=8", pc_a, fv_a, cnt_a); end
      step();
      checks++; if (pc_a !== 32'h104 || cnt_a !== 16'd9) begin
         errors++; $display("FAIL redir_next act pc=%h cnt=%h exp pc=104 cnt=9", pc_a, cnt_a); end
   endtask

   task automatic test_wait();
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         step();
         checks++; if (fv_b !== ((k % 3) == 0) || pc_b !== 32'(4 * ((k - 1) / 3))) begin
            errors++; $display("FAIL wait_pace[%0d] act fv=%b pc=%h exp fv=%b pc=%h", k, fv_b, pc_b, ((k % 3) == 0), 32'(4 * ((k - 1) / 3))); end
      end
      step();
      redirect = 1'b1; redirect_pc = 32'h40;
      #1;
      checks++; if (fl_b !== 1'b1 || wr_b !== 1'b0) begin
         errors++; $display("FAIL wait_flush act fl=%b wr=%b exp fl=1 wr=0", fl_b, wr_b); end
      step();
      redirect = 1'b0;
      checks++; if (pc_b !== 32'h40 || fv_b !== 1'b0) begin
         errors++; $display("FAIL wait_redir act pc=%h fv=%b exp pc=40 fv=0", pc_b, fv_b); end
      step();
      checks++; if (fv_b !== 1'b0) begin errors++; $display("FAIL wait_redir_hold act=%b exp=0", fv_b); end
      step();
      checks++; if (fv_b !== 1'b1 || pc_b !== 32'h40 || cnt_b !== 16'd3) begin
         errors++; $display("FAIL wait_redir_fetch act fv=%b pc=%h cnt=%h exp fv=1 pc=40 cnt=3", fv_b, pc_b, cnt_b); end
   endtask

   task automatic test_halt();
      do_reset();
      step();
      repeat (12) step();
      halt = 1'b1;
      #1;
      checks++; if (pc_a !== 32'h30 || wr_a !== 1'b1 || fl_a !== 1'b0) begin
         errors++; $display("FAIL halt_write act pc=%h wr=%b fl=%b exp pc=30 wr=1 fl=0", pc_a, wr_a, fl_a); end
      step();
      halt = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h80;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (ht_a !== 1'b1 || pc_a !== 32'h30 || fv_a !== 1'b0 || fl_a !== 1'b0 || cnt_a !== 16'd13) begin
            errors++; $display("FAIL halted[%0d] act ht=%b pc=%h fv=%b fl=%b cnt=%h exp ht=1 pc=30 fv=0 fl=0 cnt=d", i, ht_a, pc_a, fv_a, fl_a, cnt_a); end
      end
      redirect = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (pc_a !== 32'h0 || ht_a !== 1'b0 || cnt_a !== 16'h0 || fv_a !== 1'b0) begin
         errors++; $display("FAIL async_reset act pc=%h ht=%b cnt=%h fv=%b exp pc=0 ht=0 cnt=0 fv=0", pc_a, ht_a, cnt_a, fv_a); end
   endtask

   task automatic test_wrap();
      do_reset();
      step();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect = 1'b0;
      checks++; if (pc_a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align act=%h exp=fffffffc", pc_a); end
      step();
      checks++; if (pc_a !== 32'h0 || cnt_a !== 16'd1) begin
         errors++; $display("FAIL wrap_pc act pc=%h cnt=%h exp pc=0 cnt=1", pc_a, cnt_a); end
   endtask

   initial begin
      reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
      test_reset();
      test_sequence();
      test_stall();
      test_redirect();
      test_wait();
      test_halt();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences the instruction fetch datapath: owns the program counter and decides each cycle whether to advance it, hold it or redirect it. Paces fetches to a parameterised instruction-memory latency and reports when the instruction at PCResult is valid. Gives the IF/ID pipeline register its write and flush controls. Sits between the fetch datapath (PC register, adder, instruction memory) and the decode/hazard and branch-resolution logic.

Parameters:
PC_WIDTH, 32, width of PC and redirect target
RESET_PC, 0, PC value loaded during reset
IMEM_WAIT, 0, extra wait cycles per fetch (0..15); each fetch takes IMEM_WAIT+1 cycles
CNT_WIDTH, 16, width of retired-fetch counter

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Stall  in  1  hazard unit: hold current fetch
Redirect  in  1  branch/jump resolved taken: load RedirectPC
RedirectPC  in  PC_WIDTH  redirect target
Halt  in  1  decode saw halt: stop fetching
PCResult  out  PC_WIDTH  current fetch address, registered
FetchValid  out  1  instruction at PCResult is valid this cycle, registered
IFIDWrite  out  1  combinational: FetchValid & ~Stall & ~Redirect
IFIDFlush  out  1  combinational: Redirect while state is FETCH or WAIT
Halted  out  1  state is HALTED, registered
FetchCount  out  CNT_WIDTH  fetches accepted by IF/ID, saturating

Behaviour:
- Reset low (async): PCResult=RESET_PC, FetchValid=0, Halted=0, FetchCount=0, wait counter=0, state=BOOT.
- States: BOOT, WAIT, FETCH, HALTED.
- BOOT: one cycle after Reset deasserts. Next state is FETCH if IMEM_WAIT=0, else WAIT with counter=IMEM_WAIT. Redirect, Stall and Halt are ignored in BOOT.
- WAIT: FetchValid=0. Counter decrements each cycle. When counter reaches 1, go to FETCH, so FetchValid is high in the cycle after. Stall has no effect in WAIT.
- FETCH: FetchValid=1. Edge actions, in priority order:
  1) Redirect=1: PC <= {RedirectPC[PC_WIDTH-1:2],2'b00}; go to WAIT (IMEM_WAIT>0) or stay in FETCH; IFIDFlush=1 this cycle. Halt is ignored.
  2) Stall=1: hold PC and state; FetchValid stays 1; IFIDWrite=0. A Halt arriving with Stall is ignored.
  3) Halt=1: IFIDWrite=1 this cycle (the halt's successor is still written); then PC holds, state=HALTED.
  4) Otherwise: PC <= PC+4, modulo 2^PC_WIDTH so it wraps to 0; go to WAIT (IMEM_WAIT>0) or stay in FETCH.
- Redirect in WAIT: same as case 1. The wait restarts with the full IMEM_WAIT count at the new PC.
- HALTED: FetchValid=0, Halted=1, PC frozen. All inputs are ignored. Only Reset exits.
- FetchCount increments on every cycle with IFIDWrite=1 and saturates at all-ones.
- Reset asserted mid-fetch or mid-wait: all state clears immediately, without waiting for a clock edge.
- IMEM_WAIT=0: steady-state throughput is one fetch per cycle. The first FetchValid appears in the 2nd cycle after reset release.

Decomposition:
- Shared package holds:
  - state encoding constants: BOOT=2'd0, WAIT=2'd1, FETCH=2'd2, HALTED=2'd3
  - PC_INC=4
  - the redirect alignment mask
- One sub-module is natural: fetch_wait_counter, a loadable down-counter with a done flag. It is instantiated once and bypassed when IMEM_WAIT=0.

Test Plan:
- Reset low 100 ns, then release; IMEM_WAIT=0, no other inputs -> PCResult=0 in BOOT. FetchValid rises the next cycle, then PCResult steps 0,4,8,C… one per cycle. FetchCount tracks the number of steps.
- Stall high for 3 cycles at PC=0x10 -> PCResult holds 0x10, IFIDWrite=0, FetchValid=1 throughout. After release the sequence resumes at 0x14. FetchCount does not advance during the stall.
- Redirect with RedirectPC=0x103 at PC=0x20, Stall also high -> IFIDFlush=1 that cycle, next PCResult=0x100. Stall is overridden.
- IMEM_WAIT=2 -> FetchValid pulses once every 3 cycles, with PC +4 per pulse. A Redirect to 0x40 mid-wait gives PCResult=0x40 and a FetchValid 3 cycles later.
- Halt at PC=0x30 with no stall -> IFIDWrite=1 that cycle, then Halted=1, PCResult stays 0x30 and FetchValid=0 for 10 cycles. A Redirect during HALTED has no effect. Asserting Reset low mid-run gives PCResult=RESET_PC and Halted=0 immediately, without waiting for a clock edge.
- Wrap: Redirect to 0xFFFFFFFC, then advance -> PCResult becomes 0x00000000. FetchCount preloaded near all-ones saturates at 0xFFFF.
